// File: rtl/cbfp_pkg.sv
// Shared constants and types for the CBFP receive-side denormalizer.
// Chunk, index and sample typedefs plus the shift decode helpers.
package cbfp_pkg;
    localparam int NUM_PARALLEL_PATHS = 16;
    localparam int IN_W = 11;
    localparam int SAMP_W = 13;
    localparam int IDX_W = 5;
    localparam int SCALE_BASE = 2;
    localparam int BLOCK_SIZE = 512;
    localparam int NUM_CHUNKS = BLOCK_SIZE / NUM_PARALLEL_PATHS;
    localparam int SAT_W = 11;

    typedef logic [4:0] chunk_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic signed [IN_W-1:0] mant_t;
    typedef logic signed [SAMP_W-1:0] samp_t;

    localparam chunk_t LAST_CHUNK = chunk_t'(NUM_CHUNKS - 1);

    function automatic logic is_left(idx_t e);
        return e <= idx_t'(SCALE_BASE);
    endfunction

    function automatic idx_t shift_amt(idx_t e);
        return is_left(e) ? idx_t'(SCALE_BASE) - e
                          : e - idx_t'(SCALE_BASE);
    endfunction
endpackage

// File: rtl/cbfp_denorm_if.sv
// Chunk bus between a CBFP stage and the denormalizer.
// Master drives mantissas/indices, slave returns rescaled samples.
interface cbfp_denorm_if
    import cbfp_pkg::*;
#(
    parameter int OUT_W = SAMP_W
);
    mant_t [NUM_PARALLEL_PATHS-1:0] di_re;
    mant_t [NUM_PARALLEL_PATHS-1:0] di_im;
    idx_t [NUM_PARALLEL_PATHS-1:0] di_index;
    logic di_en;
    logic [NUM_PARALLEL_PATHS-1:0][OUT_W-1:0] do_re;
    logic [NUM_PARALLEL_PATHS-1:0][OUT_W-1:0] do_im;
    logic do_en;
    chunk_t do_chunk;
    logic do_last;
    logic [SAT_W-1:0] sat_count;
    logic frame_err;

    modport master (
        output di_re, di_im, di_index, di_en,
        input do_re, do_im, do_en, do_chunk,
        input do_last, sat_count, frame_err
    );

    modport slave (
        input di_re, di_im, di_index, di_en,
        output do_re, do_im, do_en, do_chunk,
        output do_last, sat_count, frame_err
    );
endinterface

// File: rtl/cbfp_denorm_lane.sv
// One component: shift, round half up, saturate to OUT_W.
// Computed wide enough that the largest right shift never wraps.
module cbfp_denorm_lane
    import cbfp_pkg::*;
#(
    parameter int OUT_W = SAMP_W
) (
    input  mant_t                    x,
    input  logic                     left,
    input  idx_t                     amt,
    output logic signed [OUT_W-1:0]  y,
    output logic                     sat
);
    localparam int W = IN_W + 2**IDX_W;
    localparam logic signed [W-1:0] MAXV =
        {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = ~MAXV;

    logic signed [W-1:0] xs;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] wide;

    always_comb begin
        xs = {{(W-IN_W){x[IN_W-1]}}, x};
        rnd = '0;
        if (!left && amt != '0)
            rnd = W'(1) << (amt - idx_t'(1));
        wide = left ? (xs <<< amt) : ((xs + rnd) >>> amt);
        y = wide[OUT_W-1:0];
        sat = 1'b0;
        if (wide > MAXV) begin
            y = MAXV[OUT_W-1:0];
            sat = 1'b1;
        end else if (wide < MINV) begin
            y = MINV[OUT_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/cbfp_denorm.sv
// CBFP receive side: two-stage rescale pipe with frame tracking
// and per-frame saturation accounting.
module cbfp_denorm
    import cbfp_pkg::*;
#(
    parameter int OUT_W = SAMP_W
) (
    input logic clk,
    input logic rst,
    cbfp_denorm_if.slave bus
);
    localparam int N = NUM_PARALLEL_PATHS;

    chunk_t cnt;
    logic ferr_q;
    logic [N-1:0] di_left;
    idx_t [N-1:0] di_amt;

    logic s1_valid;
    chunk_t s1_chunk;
    mant_t [N-1:0] s1_re;
    mant_t [N-1:0] s1_im;
    logic [N-1:0] s1_left;
    idx_t [N-1:0] s1_amt;

    logic [N-1:0][OUT_W-1:0] y_re;
    logic [N-1:0][OUT_W-1:0] y_im;
    logic [N-1:0] sat_re;
    logic [N-1:0] sat_im;
    logic [5:0] chunk_sat;

    logic s2_valid;
    chunk_t s2_chunk;
    logic [N-1:0][OUT_W-1:0] s2_re;
    logic [N-1:0][OUT_W-1:0] s2_im;
    logic [5:0] s2_sat;

    logic [SAT_W-1:0] acc;
    logic [SAT_W-1:0] base;
    logic last;

    always_comb begin
        di_left = '0;
        di_amt = '0;
        for (int i = 0; i < N; i++) begin
            di_left[i] = is_left(bus.di_index[i]);
            di_amt[i] = shift_amt(bus.di_index[i]);
        end
    end

    // A fall of di_en with a partial count is a short frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ferr_q <= 1'b0;
        end else begin
            cnt <= bus.di_en ? cnt + chunk_t'(1) : '0;
            ferr_q <= !bus.di_en && (cnt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_chunk <= '0;
            s1_re <= '0;
            s1_im <= '0;
            s1_left <= '0;
            s1_amt <= '0;
        end else begin
            s1_valid <= bus.di_en;
            s1_chunk <= cnt;
            s1_re <= bus.di_re;
            s1_im <= bus.di_im;
            s1_left <= di_left;
            s1_amt <= di_amt;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        cbfp_denorm_lane #(.OUT_W(OUT_W)) u_re (
            .x(s1_re[i]), .left(s1_left[i]), .amt(s1_amt[i]),
            .y(y_re[i]), .sat(sat_re[i])
        );
        cbfp_denorm_lane #(.OUT_W(OUT_W)) u_im (
            .x(s1_im[i]), .left(s1_left[i]), .amt(s1_amt[i]),
            .y(y_im[i]), .sat(sat_im[i])
        );
    end

    always_comb begin
        chunk_sat = '0;
        for (int i = 0; i < N; i++)
            chunk_sat = chunk_sat + 6'(sat_re[i]) + 6'(sat_im[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_chunk <= '0;
            s2_re <= '0;
            s2_im <= '0;
            s2_sat <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_chunk <= s1_valid ? s1_chunk : '0;
            s2_re <= s1_valid ? y_re : '0;
            s2_im <= s1_valid ? y_im : '0;
            s2_sat <= s1_valid ? chunk_sat : '0;
        end
    end

    // Chunk 0 restarts the sum, so leftovers of an aborted frame never leak.
    assign base = (s2_chunk == '0) ? '0 : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (s2_valid)
            acc <= last ? '0 : base + SAT_W'(s2_sat);
        else if (ferr_q)
            acc <= '0;
    end

    assign last = s2_valid && (s2_chunk == LAST_CHUNK);
    assign bus.do_en = s2_valid;
    assign bus.do_chunk = s2_chunk;
    assign bus.do_re = s2_re;
    assign bus.do_im = s2_im;
    assign bus.do_last = last;
    assign bus.sat_count = last ? base + SAT_W'(s2_sat) : '0;
    assign bus.frame_err = ferr_q;
endmodule
